// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, line levels
// and the parity helper used when checking a received word.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY_BIT,
        STOP
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    // Narrower words are zero-extended by the caller, which leaves parity unchanged.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator: one-clock tick every CLK_FREQ/(BAUD_RATE*OVERSAMPLE)
// clocks, phase-resettable through clr. Shared with the transmitter side.
module uart_baud_gen #(
    parameter int CLK_FREQ   = 16_000_000,
    parameter int BAUD_RATE  = 9_600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises the serial line, finds the start edge, samples
// each bit at its centre and presents the word with parity and framing flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int   CLK_FREQ   = 16_000_000,
    parameter int   BAUD_RATE  = 9_600,
    parameter int   OVERSAMPLE = 16,
    parameter int   PARITY     = 1,
    parameter int   DO_WIDTH   = 8,
    parameter logic STOP_LEVEL = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    output logic [DO_WIDTH-1:0] dout,
    output logic                dout_vld,
    output logic                parity_err,
    output logic                frame_err,
    output logic                busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DO_WIDTH > 1) ? $clog2(DO_WIDTH) : 1;
    localparam logic [SW-1:0] MID_CNT  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] LAST_CNT = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DO_WIDTH - 1);

    state_t              state;
    logic                rx_meta;
    logic                rx_s;
    logic                rx_q;
    logic                tick;
    logic                start_det;
    logic [SW-1:0]       scnt;
    logic [BW-1:0]       bcnt;
    logic [DO_WIDTH-1:0] shift_reg;
    logic                pbit;

    // rx_q lags rx_s so a line held low cannot look like a fresh falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= LINE_IDLE;
            rx_s    <= LINE_IDLE;
            rx_q    <= LINE_IDLE;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_q    <= rx_s;
        end
    end

    assign start_det = (state == IDLE) && (rx_q == LINE_IDLE) && (rx_s == START_BIT);

    uart_baud_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_det),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            scnt       <= '0;
            bcnt       <= '0;
            shift_reg  <= '0;
            pbit       <= 1'b0;
            dout       <= '0;
            dout_vld   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            dout_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_det) begin
                        state <= START;
                        scnt  <= '0;
                        bcnt  <= '0;
                        busy  <= 1'b1;
                    end
                end
                // A start bit that is high again at its centre was only a glitch.
                START: begin
                    if (tick) begin
                        if (scnt == MID_CNT) begin
                            scnt <= '0;
                            if (rx_s == LINE_IDLE) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (scnt == LAST_CNT) begin
                            scnt      <= '0;
                            shift_reg <= {rx_s, shift_reg[DO_WIDTH-1:1]};
                            if (bcnt == LAST_BIT) begin
                                bcnt  <= '0;
                                state <= (PARITY != 0) ? PARITY_BIT : STOP;
                            end else begin
                                bcnt <= bcnt + 1'b1;
                            end
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                end
                PARITY_BIT: begin
                    if (tick) begin
                        if (scnt == LAST_CNT) begin
                            scnt  <= '0;
                            pbit  <= rx_s;
                            state <= STOP;
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (scnt == LAST_CNT) begin
                            scnt       <= '0;
                            dout       <= shift_reg;
                            parity_err <= (PARITY != 0) && (pbit != even_parity(8'(shift_reg)));
                            frame_err  <= (rx_s != STOP_LEVEL);
                            dout_vld   <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at the nominal 9600 baud for latency,
// two faster instances (with and without parity) for the functional scenarios.
module tb_uart_rx;

    localparam int SLOW_BIT = 1664;
    localparam int FAST_BIT = 160;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_d = 1'b1;
    logic rx_p = 1'b1;
    logic rx_n = 1'b1;

    logic [7:0] dout_d, dout_p, dout_n;
    logic       vld_d, vld_p, vld_n;
    logic       perr_d, perr_p, perr_n;
    logic       ferr_d, ferr_p, ferr_n;
    logic       busy_d, busy_p, busy_n;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    int cnt_d = 0;
    int cnt_p = 0;
    int cnt_n = 0;
    int vld_cycle_d = 0;
    logic [9:0] hist_n [0:31];

    uart_rx #(
        .CLK_FREQ(16_000_000), .BAUD_RATE(9_600), .OVERSAMPLE(16),
        .PARITY(1), .DO_WIDTH(8), .STOP_LEVEL(1'b1)
    ) dut_slow (
        .clk(clk), .rst(rst_n), .rx(rx_d), .dout(dout_d), .dout_vld(vld_d),
        .parity_err(perr_d), .frame_err(ferr_d), .busy(busy_d)
    );

    uart_rx #(
        .CLK_FREQ(16_000_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
        .PARITY(1), .DO_WIDTH(8), .STOP_LEVEL(1'b1)
    ) dut_par (
        .clk(clk), .rst(rst_n), .rx(rx_p), .dout(dout_p), .dout_vld(vld_p),
        .parity_err(perr_p), .frame_err(ferr_p), .busy(busy_p)
    );

    uart_rx #(
        .CLK_FREQ(16_000_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
        .PARITY(0), .DO_WIDTH(8), .STOP_LEVEL(1'b1)
    ) dut_nopar (
        .clk(clk), .rst(rst_n), .rx(rx_n), .dout(dout_n), .dout_vld(vld_n),
        .parity_err(perr_n), .frame_err(ferr_n), .busy(busy_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (vld_d) begin
            cnt_d++;
            vld_cycle_d = cycle;
        end
        if (vld_p) cnt_p++;
        if (vld_n) begin
            if (cnt_n < 32) hist_n[cnt_n] = {perr_n, ferr_n, dout_n};
            cnt_n++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic setLine(input int line, input logic v);
        case (line)
            0:       rx_d = v;
            1:       rx_p = v;
            default: rx_n = v;
        endcase
    endtask

    task automatic holdLine(input int line, input logic v, input int clks);
        setLine(line, v);
        repeat (clks) @(posedge clk);
        #1;
    endtask

    // Line is left at the stop level so a stop of 0 can run straight into a break.
    task automatic applyStimulus(input int line, input int bit_clks, input logic [7:0] data,
                                 input bit with_par, input logic pbit, input logic stop_bit);
        holdLine(line, 1'b0, bit_clks);
        for (int i = 0; i < 8; i++) holdLine(line, data[i], bit_clks);
        if (with_par) holdLine(line, pbit, bit_clks);
        holdLine(line, stop_bit, bit_clks);
    endtask

    initial begin
        repeat (200_000) @(posedge clk);
        $display("[TB] FAIL watchdog: observed cycle %0d expected completion", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int c0;
        int lat;

        repeat (5) @(posedge clk);
        #1;
        checkOutput("rst_dout", dout_p, 8'h00);
        checkOutput("rst_vld", vld_p, 1'b0);
        checkOutput("rst_perr", perr_p, 1'b0);
        checkOutput("rst_ferr", ferr_p, 1'b0);
        checkOutput("rst_busy", busy_p, 1'b0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        // 0xA5 at nominal rate: even parity 0, expect 2 + 10.5*1664 +-1 (plus one detect clk)
        base = cnt_d;
        c0 = cycle;
        applyStimulus(0, SLOW_BIT, 8'hA5, 1'b1, 1'b0, 1'b1);
        holdLine(0, 1'b1, 20);
        lat = vld_cycle_d - c0;
        $display("[TB] start-to-valid latency %0d clk", lat);
        checkOutput("t1_pulses", cnt_d - base, 1);
        checkOutput("t1_dout", dout_d, 8'hA5);
        checkOutput("t1_perr", perr_d, 1'b0);
        checkOutput("t1_ferr", ferr_d, 1'b0);
        checkOutput("t1_busy", busy_d, 1'b0);
        checkOutput("t1_latency", (lat >= 17473 && lat <= 17475), 1'b1);

        // 0x3C has even population, so a parity bit of 1 is wrong
        base = cnt_p;
        applyStimulus(1, FAST_BIT, 8'h3C, 1'b1, 1'b1, 1'b1);
        holdLine(1, 1'b1, 20);
        checkOutput("t2_pulses", cnt_p - base, 1);
        checkOutput("t2_dout", dout_p, 8'h3C);
        checkOutput("t2_perr", perr_p, 1'b1);
        checkOutput("t2_ferr", ferr_p, 1'b0);

        base = cnt_p;
        applyStimulus(1, FAST_BIT, 8'h55, 1'b1, 1'b0, 1'b0);
        holdLine(1, 1'b0, 2 * 11 * FAST_BIT);
        checkOutput("t3_pulses", cnt_p - base, 1);
        checkOutput("t3_dout", dout_p, 8'h55);
        checkOutput("t3_ferr", ferr_p, 1'b1);
        checkOutput("t3_perr", perr_p, 1'b0);
        checkOutput("t3_busy_low", busy_p, 1'b0);
        holdLine(1, 1'b1, 400);
        checkOutput("t3_no_rearm", cnt_p - base, 1);

        base = cnt_p;
        holdLine(1, 1'b0, 2 * 11 * FAST_BIT);
        checkOutput("brk_pulses", cnt_p - base, 1);
        checkOutput("brk_dout", dout_p, 8'h00);
        checkOutput("brk_ferr", ferr_p, 1'b1);
        checkOutput("brk_perr", perr_p, 1'b0);
        holdLine(1, 1'b1, 400);
        checkOutput("brk_no_rearm", cnt_p - base, 1);

        // 30-clk glitch is well short of the 80-clk half bit
        base = cnt_p;
        holdLine(1, 1'b0, 30);
        checkOutput("t4_busy_glitch", busy_p, 1'b1);
        holdLine(1, 1'b1, 120);
        checkOutput("t4_busy_drop", busy_p, 1'b0);
        checkOutput("t4_no_pulse", cnt_p - base, 0);
        applyStimulus(1, FAST_BIT, 8'h0F, 1'b1, 1'b0, 1'b1);
        holdLine(1, 1'b1, 20);
        checkOutput("t4_pulses", cnt_p - base, 1);
        checkOutput("t4_dout", dout_p, 8'h0F);
        checkOutput("t4_errs", {perr_p, ferr_p}, 2'b00);

        base = cnt_p;
        fork
            applyStimulus(1, FAST_BIT, 8'hFF, 1'b1, 1'b0, 1'b1);
            begin
                repeat (900) @(posedge clk);
                #1;
                checkOutput("t5_busy_mid", busy_p, 1'b1);
                rst_n = 1'b0;
                #1;
                checkOutput("t5_dout", dout_p, 8'h00);
                checkOutput("t5_vld", vld_p, 1'b0);
                checkOutput("t5_perr", perr_p, 1'b0);
                checkOutput("t5_ferr", ferr_p, 1'b0);
                checkOutput("t5_busy", busy_p, 1'b0);
            end
        join
        holdLine(1, 1'b1, 10);
        rst_n = 1'b1;
        holdLine(1, 1'b1, 50);
        checkOutput("t5_no_pulse", cnt_p - base, 0);
        applyStimulus(1, FAST_BIT, 8'h81, 1'b1, 1'b0, 1'b1);
        holdLine(1, 1'b1, 20);
        checkOutput("t5_pulses", cnt_p - base, 1);
        checkOutput("t5_dout_after", dout_p, 8'h81);
        checkOutput("t5_errs_after", {perr_p, ferr_p}, 2'b00);

        // Zero idle gap between frames, then sender running 2% slow and 2% fast
        base = cnt_n;
        applyStimulus(2, FAST_BIT, 8'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus(2, FAST_BIT, 8'hFF, 1'b0, 1'b0, 1'b1);
        applyStimulus(2, FAST_BIT, 8'h12, 1'b0, 1'b0, 1'b1);
        holdLine(2, 1'b1, 20);
        checkOutput("t6_pulses", cnt_n - base, 3);
        checkOutput("t6_w0", hist_n[base], 10'h000);
        checkOutput("t6_w1", hist_n[base + 1], 10'h0FF);
        checkOutput("t6_w2", hist_n[base + 2], 10'h012);
        applyStimulus(2, 163, 8'hA5, 1'b0, 1'b0, 1'b1);
        applyStimulus(2, 157, 8'h5A, 1'b0, 1'b0, 1'b1);
        holdLine(2, 1'b1, 40);
        checkOutput("t6_sweep_pulses", cnt_n - base, 5);
        checkOutput("t6_slow_word", hist_n[base + 3], 10'h0A5);
        checkOutput("t6_fast_word", hist_n[base + 4], 10'h05A);
        checkOutput("t6_busy", busy_n, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
